// File: rtl/facto_pkg.sv
// Shared defaults and address decode helper for the factorial-core bus slaves.
package facto_pkg;

  localparam int unsigned DEF_AW        = 16;
  localparam int unsigned DEF_DW        = 64;
  localparam logic [15:0] DEF_BASE_ADDR = 16'h7000;
  localparam int unsigned ERR_CNT_W     = 8;

  typedef struct packed {
    logic [31:0] core;
    logic [31:0] idx;
  } map_t;

  // Window and stride are powers of two, so these divisions reduce to bit selects.
  function automatic map_t addr_decode(input logic [31:0] off,
                                       input int unsigned win,
                                       input int unsigned stride);
    map_t m;
    m.core = off / win;
    m.idx  = (off % win) / stride;
    return m;
  endfunction

endpackage

// File: rtl/facto_bus_decoder_if.sv
// System-bus slave port of the factorial-core decoder: request in, registered read data out.
interface facto_bus_decoder_if
  import facto_pkg::*;
#(
  parameter int unsigned AW = DEF_AW,
  parameter int unsigned DW = DEF_DW
);

  logic          s_sel;
  logic          s_wr;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_din;
  logic [DW-1:0] s_dout;
  logic          s_rvalid;

  modport master (
    output s_sel, s_wr, s_addr, s_din,
    input  s_dout, s_rvalid
  );

  modport slave (
    input  s_sel, s_wr, s_addr, s_din,
    output s_dout, s_rvalid
  );

endinterface

// File: rtl/facto_addr_map.sv
// Combinational range check and core/register-index decode for a window of equal per-core slices.
module facto_addr_map
  import facto_pkg::*;
#(
  parameter int unsigned   AW            = DEF_AW,
  parameter logic [AW-1:0] BASE_ADDR     = AW'(DEF_BASE_ADDR),
  parameter int unsigned   N_CORES       = 2,
  parameter int unsigned   REGS_PER_CORE = 8,
  parameter int unsigned   REG_STRIDE    = 8
) (
  input  logic [AW-1:0]                                  addr,
  output logic                                           hit,
  output logic [((N_CORES > 1) ? $clog2(N_CORES) : 1)-1:0] core,
  output logic [$clog2(REGS_PER_CORE)-1:0]               idx
);

  localparam int unsigned RA  = $clog2(REGS_PER_CORE);
  localparam int unsigned CW  = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam int unsigned WIN = REGS_PER_CORE * REG_STRIDE;

  // One extra bit so the window end cannot wrap at the top of the address space.
  localparam logic [AW:0] LO = {1'b0, BASE_ADDR};
  localparam logic [AW:0] HI = LO + (AW+1)'(N_CORES * WIN);

  logic [AW:0] addr_x;
  logic [AW:0] off;
  map_t        m;
  logic        unused_ok;

  always_comb begin
    addr_x = {1'b0, addr};
    off    = addr_x - LO;
    hit    = (addr_x >= LO) && (addr_x < HI);
    m      = addr_decode(32'(off), WIN, REG_STRIDE);
    core   = CW'(m.core);
    idx    = RA'(m.idx);
  end

  assign unused_ok = ^{m.core[31:CW], m.idx[31:RA]};

endmodule

// File: rtl/facto_bus_decoder.sv
// Registered bus-slave decoder: routes requests to one of N_CORES register files and returns read data.
module facto_bus_decoder
  import facto_pkg::*;
#(
  parameter int unsigned   AW            = DEF_AW,
  parameter logic [AW-1:0] BASE_ADDR     = AW'(DEF_BASE_ADDR),
  parameter int unsigned   N_CORES       = 2,
  parameter int unsigned   REGS_PER_CORE = 8,
  parameter int unsigned   REG_STRIDE    = 8,
  parameter int unsigned   DW            = DEF_DW
) (
  input  logic                              clk,
  input  logic                              reset_n,
  facto_bus_decoder_if.slave                bus,
  output logic [N_CORES-1:0]                c_sel,
  output logic                              c_wr,
  output logic [$clog2(REGS_PER_CORE)-1:0]  c_addr,
  output logic [DW-1:0]                     c_din,
  input  logic [N_CORES*DW-1:0]             c_dout,
  output logic                              err,
  output logic [ERR_CNT_W-1:0]              err_cnt,
  output logic [AW-1:0]                     err_addr,
  input  logic                              err_clr
);

  localparam int unsigned RA = $clog2(REGS_PER_CORE);
  localparam int unsigned CW = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == '1) ? v : v + ERR_CNT_W'(1);
  endfunction

  logic          hit;
  logic [CW-1:0] core;
  logic [RA-1:0] idx;
  logic          new_err;
  logic          vld_p1;
  logic [DW-1:0] rd_mux_p1;
  logic [DW-1:0] s_dout_p2;
  logic          vld_p2;
  logic          err_armed;

  facto_addr_map #(
    .AW            (AW),
    .BASE_ADDR     (BASE_ADDR),
    .N_CORES       (N_CORES),
    .REGS_PER_CORE (REGS_PER_CORE),
    .REG_STRIDE    (REG_STRIDE)
  ) u_map (
    .addr (bus.s_addr),
    .hit  (hit),
    .core (core),
    .idx  (idx)
  );

  assign new_err = bus.s_sel && !hit;

  // Stage 1: request register toward the cores
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c_sel  <= '0;
      c_wr   <= 1'b0;
      c_addr <= '0;
      c_din  <= '0;
      vld_p1 <= 1'b0;
      err    <= 1'b0;
    end else begin
      c_sel  <= '0;
      c_wr   <= 1'b0;
      vld_p1 <= 1'b0;
      err    <= new_err;
      if (bus.s_sel) begin
        if (hit) c_sel <= N_CORES'(1) << core;
        c_wr   <= bus.s_wr;
        c_addr <= idx;
        c_din  <= bus.s_din;
        vld_p1 <= !bus.s_wr;
      end
    end
  end

  // An unmapped read leaves c_sel at zero, so the mux naturally returns zero.
  always_comb begin
    rd_mux_p1 = '0;
    for (int unsigned k = 0; k < N_CORES; k++) begin
      if (c_sel[k]) rd_mux_p1 = rd_mux_p1 | c_dout[k*DW +: DW];
    end
  end

  // Stage 2: registered read return
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_dout_p2 <= '0;
      vld_p2    <= 1'b0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) s_dout_p2 <= rd_mux_p1;
    end
  end

  assign bus.s_dout   = s_dout_p2;
  assign bus.s_rvalid = vld_p2;

  // A new error takes priority over a same-cycle clear and counts as the first one after it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt   <= '0;
      err_addr  <= '0;
      err_armed <= 1'b1;
    end else if (new_err) begin
      err_cnt   <= err_clr ? ERR_CNT_W'(1) : sat_inc(err_cnt);
      if (err_armed || err_clr) err_addr <= bus.s_addr;
      err_armed <= 1'b0;
    end else if (err_clr) begin
      err_cnt   <= '0;
      err_armed <= 1'b1;
    end
  end

endmodule

// File: tb/tb_facto_bus_decoder.sv
// Scoreboard bench for facto_bus_decoder: directed requests queue expectations, a monitor checks outputs.
module tb_facto_bus_decoder;
  import facto_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic err_clr;

  facto_bus_decoder_if #(.AW(16), .DW(64)) bus ();
  facto_bus_decoder_if #(.AW(16), .DW(64)) bus4 ();

  logic [1:0]   c_sel;
  logic         c_wr;
  logic [2:0]   c_addr;
  logic [63:0]  c_din;
  logic [127:0] c_dout;
  logic         err;
  logic [7:0]   err_cnt;
  logic [15:0]  err_addr;

  logic [3:0]   c_sel4;
  logic         c_wr4;
  logic [2:0]   c_addr4;
  logic [63:0]  c_din4;
  logic [255:0] c_dout4;
  logic         err4;
  logic [7:0]   err_cnt4;
  logic [15:0]  err_addr4;

  facto_bus_decoder #(.AW(16), .BASE_ADDR(16'h7000), .N_CORES(2),
                      .REGS_PER_CORE(8), .REG_STRIDE(8), .DW(64)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .c_sel(c_sel), .c_wr(c_wr), .c_addr(c_addr), .c_din(c_din), .c_dout(c_dout),
    .err(err), .err_cnt(err_cnt), .err_addr(err_addr), .err_clr(err_clr)
  );

  facto_bus_decoder #(.AW(16), .BASE_ADDR(16'h7000), .N_CORES(4),
                      .REGS_PER_CORE(8), .REG_STRIDE(8), .DW(64)) dut4 (
    .clk(clk), .reset_n(reset_n), .bus(bus4),
    .c_sel(c_sel4), .c_wr(c_wr4), .c_addr(c_addr4), .c_din(c_din4), .c_dout(c_dout4),
    .err(err4), .err_cnt(err_cnt4), .err_addr(err_addr4), .err_clr(1'b0)
  );

  // Core register model: core k, register i reads as C0DE..._0000 + k*256 + i.
  always_comb begin
    c_dout = '0;
    for (int k = 0; k < 2; k++)
      c_dout[k*64 +: 64] = 64'hC0DE_0000_0000_0000 + 64'(k * 256) + 64'(c_addr);
  end
  assign c_dout4 = '0;

  typedef struct {
    logic [1:0]  sel;
    logic        wr;
    logic [2:0]  addr;
    logic [63:0] din;
    logic        err;
  } cexp_t;

  cexp_t       cq[$];
  logic [63:0] rq[$];
  cexp_t       mon_e;
  logic [63:0] mon_r;
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (c_sel != 2'b00 || err) begin
      if (cq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL c_stage_spurious: got sel=%b err=%b expected no request", c_sel, err);
      end else begin
        mon_e = cq.pop_front();
        chk("c_sel", 64'(c_sel), 64'(mon_e.sel));
        chk("err_pulse", 64'(err), 64'(mon_e.err));
        if (!mon_e.err) begin
          chk("c_wr", 64'(c_wr), 64'(mon_e.wr));
          chk("c_addr", 64'(c_addr), 64'(mon_e.addr));
          chk("c_din", c_din, mon_e.din);
        end
      end
    end
    if (bus.s_rvalid) begin
      if (rq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rvalid_spurious: got s_rvalid=1 expected 0 (s_dout=%0h)", bus.s_dout);
      end else begin
        mon_r = rq.pop_front();
        chk("s_dout", bus.s_dout, mon_r);
      end
    end
  end

  task automatic issue(input logic [15:0] a, input logic w, input logic [63:0] d,
                       input logic [1:0] esel, input logic [2:0] eidx, input logic [63:0] erd);
    cexp_t e;
    bus.s_sel  = 1'b1;
    bus.s_wr   = w;
    bus.s_addr = a;
    bus.s_din  = d;
    e.sel  = esel;
    e.wr   = w;
    e.addr = eidx;
    e.din  = d;
    e.err  = (esel == 2'b00);
    cq.push_back(e);
    if (!w) rq.push_back(erd);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    bus.s_sel = 1'b0;
    bus.s_wr  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_c_sel"}, 64'(c_sel), 64'd0);
    chk({tag, "_c_wr"}, 64'(c_wr), 64'd0);
    chk({tag, "_c_addr"}, 64'(c_addr), 64'd0);
    chk({tag, "_c_din"}, c_din, 64'd0);
    chk({tag, "_s_dout"}, bus.s_dout, 64'd0);
    chk({tag, "_s_rvalid"}, 64'(bus.s_rvalid), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
    chk({tag, "_err_cnt"}, 64'(err_cnt), 64'd0);
    chk({tag, "_err_addr"}, 64'(err_addr), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    err_clr = 1'b0;
    bus.s_sel = 1'b0; bus.s_wr = 1'b0; bus.s_addr = '0; bus.s_din = '0;
    bus4.s_sel = 1'b0; bus4.s_wr = 1'b0; bus4.s_addr = '0; bus4.s_din = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset_n = 1'b1;
    idle(1);

    issue(16'h7000, 1'b0, 64'hAAAA, 2'b01, 3'd0, 64'hC0DE_0000_0000_0000);
    idle(3);

    issue(16'h7047, 1'b1, 64'h1234, 2'b10, 3'd0, 64'd0);
    idle(3);

    issue(16'h703F, 1'b0, 64'h1, 2'b01, 3'd7, 64'hC0DE_0000_0000_0007);
    issue(16'h7040, 1'b0, 64'h2, 2'b10, 3'd0, 64'hC0DE_0000_0000_0100);
    idle(3);

    issue(16'h6FFF, 1'b0, 64'h3, 2'b00, 3'd0, 64'd0);
    issue(16'h7080, 1'b0, 64'h4, 2'b00, 3'd0, 64'd0);
    idle(2);
    chk("err_cnt_two", 64'(err_cnt), 64'd2);
    chk("err_addr_first", 64'(err_addr), 64'h6FFF);

    for (int i = 0; i < 300; i++)
      issue(16'h9000, 1'b1, 64'd0, 2'b00, 3'd0, 64'd0);
    idle(1);
    chk("err_cnt_sat", 64'(err_cnt), 64'd255);
    chk("err_addr_held", 64'(err_addr), 64'h6FFF);

    err_clr = 1'b1;
    issue(16'h8000, 1'b1, 64'd0, 2'b00, 3'd0, 64'd0);
    err_clr = 1'b0;
    idle(1);
    chk("err_cnt_clr_err", 64'(err_cnt), 64'd1);
    chk("err_addr_clr_err", 64'(err_addr), 64'h8000);

    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    chk("err_cnt_cleared", 64'(err_cnt), 64'd0);
    issue(16'h9100, 1'b0, 64'd0, 2'b00, 3'd0, 64'd0);
    idle(2);
    chk("err_addr_rearm", 64'(err_addr), 64'h9100);

    // Read at 0x7010, then reset before its data returns.
    bus.s_sel = 1'b1; bus.s_wr = 1'b0; bus.s_addr = 16'h7010; bus.s_din = 64'h55;
    @(posedge clk); #1;
    bus.s_sel = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(4);

    bus4.s_sel = 1'b1; bus4.s_wr = 1'b0; bus4.s_addr = 16'h70C8;
    @(posedge clk); #1;
    chk("n4_c_sel", 64'(c_sel4), 64'b1000);
    chk("n4_c_addr", 64'(c_addr4), 64'd1);
    chk("n4_err_mapped", 64'(err4), 64'd0);
    bus4.s_addr = 16'h7100;
    @(posedge clk); #1;
    bus4.s_sel = 1'b0;
    chk("n4_c_sel_unmapped", 64'(c_sel4), 64'd0);
    chk("n4_err_unmapped", 64'(err4), 64'd1);
    idle(2);

    chk("cq_drained", 64'(cq.size()), 64'd0);
    chk("rq_drained", 64'(rq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/facto_bus_decoder.md
# facto_bus_decoder

Parametrised, registered bus-slave decoder for one or more factorial cores. It maps a contiguous address window starting at BASE_ADDR onto N_CORES equal sub-windows, each holding REGS_PER_CORE registers spaced REG_STRIDE bytes apart. It routes each request to exactly one core with a one-cycle registered select, returns read data through a registered mux, and flags and counts accesses to unmapped addresses. It sits between the system bus slave port and the per-core register files.

## Interface
- BASE_ADDR, 16'h7000, first byte of core 0 window
- N_CORES, 2, number of cores (1..8)
- REGS_PER_CORE, 8, registers per core, power of two (2..16)
- REG_STRIDE, 8, bytes per register, power of two
- AW, 16, address width
- DW, 64, data width
- RA = log2(REGS_PER_CORE) (local); WIN = REGS_PER_CORE*REG_STRIDE (local)

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- s_sel  in  1  bus request valid
- s_wr  in  1  1 = write, 0 = read
- s_addr  in  AW  byte address
- s_din  in  DW  write data
- s_dout  out  DW  read data, registered
- s_rvalid  out  1  one-cycle pulse, s_dout valid
- c_sel  out  N_CORES  one-hot core select, registered
- c_wr  out  1  registered write strobe qualifier
- c_addr  out  RA  registered register index
- c_din  out  DW  registered write data
- c_dout  in  N_CORES*DW  core read data, core k at [k*DW +: DW]
- err  out  1  one-cycle pulse, unmapped access
- err_cnt  out  8  saturating unmapped-access count
- err_addr  out  AW  address of first unmapped access since clear
- err_clr  in  1  clears err_cnt and re-arms err_addr capture

## Operation
- Mapped range: BASE_ADDR <= s_addr < BASE_ADDR + N_CORES*WIN. off = s_addr - BASE_ADDR; core = off / WIN; index = (off mod WIN) / REG_STRIDE. Low log2(REG_STRIDE) bits ignored; any byte inside a register slot hits that register.
- Stage 1 (request): on s_sel, register c_sel = onehot(core), c_wr = s_wr, c_addr = index, c_din = s_din. Without s_sel, c_sel = 0 and c_wr = 0; c_addr and c_din hold.
- Stage 2 (read return): if stage 1 held a mapped read, s_dout <= c_dout slice of the selected core, s_rvalid = 1. An unmapped read yields s_dout = 0 with s_rvalid = 1. Writes produce no s_rvalid.
- Unmapped access (s_sel = 1, address out of range): c_sel = 0, err pulses in stage 1, err_cnt increments and saturates at 255, err_addr captured only if no error is latched since the last clear.
- err_clr and a new error in the same cycle: error wins, err_cnt = 1, err_addr = new address.
- Back-to-back requests are accepted every cycle; no stall and no backpressure.
- Reset clears all outputs: c_sel = 0, c_wr = 0, c_addr = 0, c_din = 0, s_dout = 0, s_rvalid = 0, err = 0, err_cnt = 0, err_addr = 0, capture armed. Reset mid-transaction drops any in-flight read; no s_rvalid is issued.

## Timing
- Request at edge n: c_* valid after edge n+1.
- Read data: s_dout and s_rvalid valid after edge n+2 (2-cycle latency). The core must present c_dout combinationally from c_sel/c_addr within the cycle.
- err pulses after edge n+1. err_cnt and err_addr update at the same edge.

## Structure
- Shared package facto_pkg: default BASE_ADDR, DW, AW, the err_cnt width, and a function for the address-to-(core, index) decode.
- One natural sub-module, facto_addr_map: combinational range check plus core/index decode, reusable by other bus slaves. The registers and read mux stay in the top level.

## Test plan
- Defaults. Read 0x7000 -> c_sel = 01, c_addr = 0 at +1; s_dout = core0 reg value, s_rvalid at +2.
- Write 0x7047 with data 0x1234 -> c_sel = 10, c_addr = 0, c_wr = 1, c_din = 0x1234; no s_rvalid.
- Read 0x703F then 0x7040 on consecutive cycles -> core0 index 7, then core1 index 0; two s_rvalid pulses on consecutive cycles with the correct data.
- Read 0x6FFF, then 0x7080 -> err pulses twice, err_cnt = 2, err_addr = 0x6FFF, s_dout = 0 with s_rvalid; c_sel stays 0.
- 300 unmapped accesses -> err_cnt = 255. Then err_clr together with an error at 0x8000 -> err_cnt = 1, err_addr = 0x8000.
- Issue a read at 0x7010, assert reset_n low on the next cycle -> all outputs 0 immediately, no s_rvalid after release; N_CORES = 4 build maps 0x70C8 to core3 index 1.
